// File: rtl/codificador_hamming_tx.sv
// ---------------------------------------------------------------------------
// codificador_hamming_tx
//
// Transmit side of the SECDED link. A 4-bit nibble accepted over a
// valid/ready handshake is encoded into an 8-bit extended-Hamming codeword
// laid out as {g0,w3,w2,w1,p2,w0,p1,p0}. The optional error mask is XORed
// onto the word. The result is presented in parallel and shifted out LSB
// first in a UART-style frame: one start bit (0), eight data bits, one stop
// bit (1).
//
// Parameters:
//   CLKS_PER_BIT      clock cycles per serial bit (>= 1)
//
// Ports:
//   clk               rising-edge clock
//   rst_n             synchronous active-low reset
//   dato_i[3:0]       data nibble {w3,w2,w1,w0}
//   valid_i           data request
//   ready_o           idle, will accept data this cycle
//   error_mask_i[7:0] error-injection mask, sampled at the handshake
//   codeword_o[7:0]   registered transmitted codeword (mask applied)
//   codeword_valid_o  one-cycle pulse when codeword_o updates
//   tx_o              serial line, idle high
//   busy_o            frame in progress
//   done_o            one-cycle pulse when a frame completes
// ---------------------------------------------------------------------------
module codificador_hamming_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dato_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [7:0] error_mask_i,
    output logic [7:0] codeword_o,
    output logic       codeword_valid_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [CW-1:0]  r_baud;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic [7:0]     r_codeword;
    logic           r_cw_valid;
    logic           r_done;

    logic           w_baud_last;
    logic           w_handshake;
    logic           w_p0;
    logic           w_p1;
    logic           w_p2;
    logic           w_g0;
    logic [7:0]     w_codeword;
    logic [7:0]     w_tx_word;

    // ------------------------------------------------------------------
    // Encoder: even parity; g0 covers the seven Hamming bits and is
    // computed before the mask is applied.
    // ------------------------------------------------------------------
    assign w_p0       = dato_i[0] ^ dato_i[1] ^ dato_i[3];
    assign w_p1       = dato_i[0] ^ dato_i[2] ^ dato_i[3];
    assign w_p2       = dato_i[1] ^ dato_i[2] ^ dato_i[3];
    assign w_g0       = ^{dato_i[3], dato_i[2], dato_i[1], w_p2, dato_i[0], w_p1, w_p0};
    assign w_codeword = {w_g0, dato_i[3], dato_i[2], dato_i[1], w_p2, dato_i[0], w_p1, w_p0};
    assign w_tx_word  = w_codeword ^ error_mask_i;

    assign w_baud_last = (r_baud == CW'(CLKS_PER_BIT - 1));
    assign w_handshake = valid_i && (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_handshake) w_next_state = S_START;
            S_START: if (w_baud_last) w_next_state = S_DATA;
            S_DATA:  if (w_baud_last && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
            S_STOP:  if (w_baud_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: baud counter, bit index, shift register, output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_codeword <= '0;
            r_cw_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cw_valid <= 1'b0;
            r_done     <= 1'b0;

            // The last count of every bit period coincides with either a
            // state change or a new data bit, so clearing on it covers both.
            if ((r_state == S_IDLE) || w_baud_last) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end

            if (w_handshake) begin
                r_codeword <= w_tx_word;
                r_shift    <= w_tx_word;
                r_cw_valid <= 1'b1;
                r_bit_idx  <= '0;
            end

            // Index wraps 7 -> 0 on the last data bit, ready for the next frame.
            if ((r_state == S_DATA) && w_baud_last) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if ((r_state == S_STOP) && w_baud_last) begin
                r_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        tx_o = 1'b1;
        case (r_state)
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = r_shift[0];
            default: tx_o = 1'b1;
        endcase
    end

    assign ready_o          = (r_state == S_IDLE);
    assign busy_o           = (r_state != S_IDLE);
    assign codeword_o       = r_codeword;
    assign codeword_valid_o = r_cw_valid;
    assign done_o           = r_done;

endmodule

// File: tb/tb_codificador_hamming_tx.sv
module tb_codificador_hamming_tx;

    logic       clk;
    int         n_checks;
    int         n_err;

    // Instance with CLKS_PER_BIT = 4
    logic       rst4_n;
    logic [3:0] d4_dato;
    logic       d4_valid;
    logic       d4_ready;
    logic [7:0] d4_mask;
    logic [7:0] d4_cw;
    logic       d4_cwv;
    logic       d4_tx;
    logic       d4_busy;
    logic       d4_done;

    // Instance with CLKS_PER_BIT = 1
    logic       rst1_n;
    logic [3:0] d1_dato;
    logic       d1_valid;
    logic       d1_ready;
    logic [7:0] d1_mask;
    logic [7:0] d1_cw;
    logic       d1_cwv;
    logic       d1_tx;
    logic       d1_busy;
    logic       d1_done;

    codificador_hamming_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk              (clk),
        .rst_n            (rst4_n),
        .dato_i           (d4_dato),
        .valid_i          (d4_valid),
        .ready_o          (d4_ready),
        .error_mask_i     (d4_mask),
        .codeword_o       (d4_cw),
        .codeword_valid_o (d4_cwv),
        .tx_o             (d4_tx),
        .busy_o           (d4_busy),
        .done_o           (d4_done)
    );

    codificador_hamming_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk              (clk),
        .rst_n            (rst1_n),
        .dato_i           (d1_dato),
        .valid_i          (d1_valid),
        .ready_o          (d1_ready),
        .error_mask_i     (d1_mask),
        .codeword_o       (d1_cw),
        .codeword_valid_o (d1_cwv),
        .tx_o             (d1_tx),
        .busy_o           (d1_busy),
        .done_o           (d1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: classic Hamming(7,4) by bit position (position j
    // lives in codeword bit j-1), parity bit 2^k covers every position
    // whose index has bit k set; bit 7 makes the whole word even.
    function automatic logic [7:0] ref_encode(input logic [3:0] d);
        logic [7:0] p;
        logic [7:0] cw;
        logic       par;
        p    = '0;
        p[3] = d[0];
        p[5] = d[1];
        p[6] = d[2];
        p[7] = d[3];
        for (int k = 0; k < 3; k++) begin
            par = 1'b0;
            for (int j = 1; j <= 7; j++) begin
                if (((j & (1 << k)) != 0) && (j != (1 << k))) par = par ^ p[j];
            end
            p[1 << k] = par;
        end
        cw[6:0] = p[7:1];
        cw[7]   = ^p[7:1];
        return cw;
    endfunction

    // Receiver-side syndrome {overall parity, s2, s1, s0}
    function automatic logic [3:0] ref_syndrome(input logic [7:0] cw);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 1; j <= 7; j++) begin
                if ((j & (1 << k)) != 0) s[k] = s[k] ^ cw[j-1];
            end
        end
        s[3] = ^cw;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input bit sel);
        return sel ? d1_tx : d4_tx;
    endfunction
    function automatic logic get_ready(input bit sel);
        return sel ? d1_ready : d4_ready;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? d1_busy : d4_busy;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? d1_done : d4_done;
    endfunction
    function automatic logic get_cwv(input bit sel);
        return sel ? d1_cwv : d4_cwv;
    endfunction
    function automatic logic [7:0] get_cw(input bit sel);
        return sel ? d1_cw : d4_cw;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [3:0] d, input logic [7:0] m);
        if (sel) begin
            d1_valid = v; d1_dato = d; d1_mask = m;
        end else begin
            d4_valid = v; d4_dato = d; d4_mask = m;
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge of the
    // done cycle. With hold set, valid stays high and the data/mask inputs
    // change mid-frame to mid_data / a random mask.
    task automatic frame(input bit sel, input logic [3:0] data, input logic [7:0] mask,
                         input bit hold, input logic [3:0] mid_data);
        int unsigned cpb;
        logic [7:0]  word;
        int unsigned b;
        logic        exp_tx;
        cpb  = sel ? 1 : 4;
        word = ref_encode(data) ^ mask;
        drive(sel, 1'b1, data, mask);
        @(posedge clk);
        @(negedge clk);
        chk("cw_after_hs",  32'(get_cw(sel)),    32'(word));
        chk("cwv_after_hs", 32'(get_cwv(sel)),   32'd1);
        chk("ready_low",    32'(get_ready(sel)), 32'd0);
        chk("busy_high",    32'(get_busy(sel)),  32'd1);
        if (hold) drive(sel, 1'b1, mid_data, 8'($urandom));
        else      drive(sel, 1'b0, data, mask);
        for (int unsigned c = 0; c < 10 * cpb; c++) begin
            if (c != 0) @(negedge clk);
            b = c / cpb;
            if (b == 0)      exp_tx = 1'b0;
            else if (b <= 8) exp_tx = word[b-1];
            else             exp_tx = 1'b1;
            chk($sformatf("tx_c%0d", c), 32'(get_tx(sel)), 32'(exp_tx));
            chk("done_in_frame",  32'(get_done(sel)),  32'd0);
            chk("ready_in_frame", 32'(get_ready(sel)), 32'd0);
            if (c != 0) chk("cwv_in_frame", 32'(get_cwv(sel)), 32'd0);
        end
        @(negedge clk);
        chk("done_pulse",  32'(get_done(sel)),  32'd1);
        chk("ready_back",  32'(get_ready(sel)), 32'd1);
        chk("tx_idle",     32'(get_tx(sel)),    32'd1);
        chk("cw_held",     32'(get_cw(sel)),    32'(word));
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] b2;
        logic [7:0] m;
        logic [7:0] word;
        int         done_cnt;

        n_checks = 0;
        n_err    = 0;
        rst4_n = 1'b0; rst1_n = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b1, 1'b0, 4'h0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", 32'(get_ready(s[0])), 32'd1);
            chk("rst_busy",  32'(get_busy(s[0])),  32'd0);
            chk("rst_tx",    32'(get_tx(s[0])),    32'd1);
            chk("rst_cw",    32'(get_cw(s[0])),    32'h00);
            chk("rst_cwv",   32'(get_cwv(s[0])),   32'd0);
            chk("rst_done",  32'(get_done(s[0])),  32'd0);
        end
        rst4_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);

        // Directed: 1011, no mask -> 0x55
        frame(1'b0, 4'b1011, 8'h00, 1'b0, 4'h0);
        chk("cw_1011", 32'(d4_cw), 32'h55);
        @(negedge clk);

        // Error injection: mask 0x04 -> 0x51
        frame(1'b0, 4'b1011, 8'h04, 1'b0, 4'h0);
        chk("cw_1011_m04", 32'(d4_cw), 32'h51);
        @(negedge clk);

        // Randomized frames with random masks
        repeat (4) begin
            a = 4'($urandom);
            m = 8'($urandom);
            frame(1'b0, a, m, 1'b0, 4'h0);
            @(negedge clk);
        end

        // Busy rejection and back-to-back
        a  = 4'($urandom);
        b2 = ~a;
        frame(1'b0, a, 8'($urandom), 1'b1, b2);
        frame(1'b0, b2, 8'h00, 1'b0, 4'h0);
        @(negedge clk);

        // Reset during DATA bit 3
        a    = 4'($urandom);
        word = ref_encode(a);
        drive(1'b0, 1'b1, a, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, a, 8'h00);
        repeat (17) @(negedge clk);
        chk("tx_bit3_before_rst", 32'(d4_tx), 32'(word[3]));
        rst4_n = 1'b0;
        @(negedge clk);
        rst4_n = 1'b1;
        chk("midrst_tx",    32'(d4_tx),    32'd1);
        chk("midrst_ready", 32'(d4_ready), 32'd1);
        chk("midrst_busy",  32'(d4_busy),  32'd0);
        chk("midrst_cw",    32'(d4_cw),    32'h00);
        done_cnt = (d4_done === 1'b1) ? 1 : 0;
        repeat (50) begin
            @(negedge clk);
            if (d4_done === 1'b1) done_cnt++;
        end
        chk("midrst_no_done", 32'(done_cnt), 32'd0);

        // Encoding sweep on the single-cycle-per-bit instance
        for (int n = 0; n < 16; n++) begin
            frame(1'b1, 4'(n), 8'h00, 1'b0, 4'h0);
            chk($sformatf("syndrome_%0d", n), 32'(ref_syndrome(d1_cw)), 32'd0);
            if (n == 0)  chk("cw_0", 32'(d1_cw), 32'h00);
            if (n == 1)  chk("cw_1", 32'(d1_cw), 32'h87);
            if (n == 15) chk("cw_F", 32'(d1_cw), 32'hFF);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
